// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc -- multi-cycle ALU for the execute stage.
//
// Sixteen RV32IM-style operations. Single-cycle ops (ADD..SRA) complete one
// cycle after accept; MUL/MULHU use an XLEN-step shift-add multiplier and
// DIV/DIVU/REM/REMU an XLEN-step restoring divider. Every result is
// registered and held until the consumer takes it.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready request handshake
//   ctrl                4-bit opcode
//   rs1, rs2            operands A and B
//   flush               synchronous abort of any in-flight or held op
//   out_valid/out_ready result handshake
//   rd                  result
//   z                   rs1 == rs2 of the op that produced rd
//   err                 unsupported op (MULDIV_EN = 0)
// ---------------------------------------------------------------------------
module alu_mc #(
    parameter int XLEN      = 32,
    parameter bit MULDIV_EN = 1'b1,
    parameter int CNT_W     = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      ctrl,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd,
    output logic            z,
    output logic            err
);

    localparam int SH_W = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef enum logic [3:0] {
        OP_ADD   = 4'b0000, OP_SUB   = 4'b0001, OP_AND  = 4'b0010,
        OP_OR    = 4'b0011, OP_XOR   = 4'b0100, OP_SLT  = 4'b0101,
        OP_SLTU  = 4'b0110, OP_SLL   = 4'b0111, OP_SRL  = 4'b1000,
        OP_SRA   = 4'b1001, OP_MUL   = 4'b1010, OP_MULHU = 4'b1011,
        OP_DIV   = 4'b1100, OP_DIVU  = 4'b1101, OP_REM  = 4'b1110,
        OP_REMU  = 4'b1111
    } op_t;

    state_t            state;
    op_t               op;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   acc;      // mul: high product half; div: partial remainder
    logic [XLEN-1:0]   quo;      // mul: multiplier/low half; div: dividend/quotient
    logic [XLEN-1:0]   dvs;      // mul: multiplicand; div: divisor magnitude
    logic              neg_q;
    logic              neg_r;
    logic              z_cap;

    // Request decode
    logic              accept;
    logic              eq;
    logic              is_simple;
    logic              is_mul;
    logic              is_div;
    logic              is_rem;
    logic              is_sdiv;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [SH_W-1:0]   shamt;
    logic [XLEN-1:0]   simple_res;

    // Iteration step
    logic [XLEN:0]     msum;
    logic [XLEN:0]     rsh;
    logic              ge;
    logic [XLEN-1:0]   step_acc;
    logic [XLEN-1:0]   step_quo;
    logic [XLEN-1:0]   fin_res;

    assign in_ready = !flush && ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept   = in_valid && in_ready;

    assign eq        = (rs1 == rs2);
    assign is_simple = (ctrl <= 4'd9);
    assign is_mul    = (ctrl == OP_MUL) || (ctrl == OP_MULHU);
    assign is_div    = (ctrl[3:2] == 2'b11);
    assign is_rem    = (ctrl == OP_REM) || (ctrl == OP_REMU);
    assign is_sdiv   = (ctrl == OP_DIV) || (ctrl == OP_REM);
    assign mag_a     = (is_sdiv && rs1[XLEN-1]) ? -rs1 : rs1;
    assign mag_b     = (is_sdiv && rs2[XLEN-1]) ? -rs2 : rs2;
    assign shamt     = rs2[SH_W-1:0];

    always_comb begin
        simple_res = '0;
        case (op_t'(ctrl))
            OP_ADD:  simple_res = rs1 + rs2;
            OP_SUB:  simple_res = rs1 - rs2;
            OP_AND:  simple_res = rs1 & rs2;
            OP_OR:   simple_res = rs1 | rs2;
            OP_XOR:  simple_res = rs1 ^ rs2;
            OP_SLT:  simple_res[0] = ($signed(rs1) < $signed(rs2));
            OP_SLTU: simple_res[0] = (rs1 < rs2);
            OP_SLL:  simple_res = rs1 << shamt;
            OP_SRL:  simple_res = rs1 >> shamt;
            OP_SRA:  simple_res = $unsigned($signed(rs1) >>> shamt);
            default: simple_res = '0;
        endcase
    end

    // One multiply or divide step. The divide remainder stays below the
    // divisor, so the shifted remainder fits in XLEN+1 bits and the
    // difference after a successful trial fits back in XLEN bits.
    always_comb begin
        msum     = {1'b0, acc} + (quo[0] ? {1'b0, dvs} : '0);
        rsh      = {acc, quo[XLEN-1]};
        ge       = (rsh >= {1'b0, dvs});
        step_acc = acc;
        step_quo = quo;
        if ((op == OP_MUL) || (op == OP_MULHU)) begin
            step_acc = msum[XLEN:1];
            step_quo = {msum[0], quo[XLEN-1:1]};
        end else begin
            step_acc = ge ? (rsh[XLEN-1:0] - dvs) : rsh[XLEN-1:0];
            step_quo = {quo[XLEN-2:0], ge};
        end
    end

    always_comb begin
        fin_res = '0;
        case (op)
            OP_MUL:   fin_res = step_quo;
            OP_MULHU: fin_res = step_acc;
            OP_DIV:   fin_res = neg_q ? -step_quo : step_quo;
            OP_DIVU:  fin_res = step_quo;
            OP_REM:   fin_res = neg_r ? -step_acc : step_acc;
            OP_REMU:  fin_res = step_acc;
            default:  fin_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            rd        <= '0;
            z         <= 1'b0;
            err       <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            quo       <= '0;
            dvs       <= '0;
            op        <= OP_ADD;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            z_cap     <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        op    <= op_t'(ctrl);
                        z_cap <= eq;
                        if (is_simple) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            rd        <= simple_res;
                            z         <= eq;
                            err       <= 1'b0;
                        end else if (!MULDIV_EN) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            rd        <= '0;
                            z         <= eq;
                            err       <= 1'b1;
                        end else if (is_div && (rs2 == '0)) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            rd        <= is_rem ? rs1 : '1;
                            z         <= eq;
                            err       <= 1'b0;
                        end else begin
                            // z is parked in z_cap so rd/z/err only move on entry to DONE
                            state     <= BUSY;
                            out_valid <= 1'b0;
                            cnt       <= CNT_W'(XLEN);
                            acc       <= '0;
                            quo       <= is_mul ? rs2 : mag_a;
                            dvs       <= is_mul ? rs1 : mag_b;
                            neg_q     <= is_sdiv && (rs1[XLEN-1] ^ rs2[XLEN-1]);
                            neg_r     <= is_sdiv && rs1[XLEN-1];
                        end
                    end else if ((state == DONE) && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                BUSY: begin
                    acc <= step_acc;
                    quo <= step_quo;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        rd        <= fin_res;
                        z         <= z_cap;
                        err       <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// ---------------------------------------------------------------------------
// tb_alu_mc -- scoreboard bench for alu_mc (XLEN = 32).
// The driver pushes the expected response for every accepted op; a monitor
// pops and compares whenever the DUT presents a result. A second instance
// with MULDIV_EN = 0 covers the unsupported-op path.
// ---------------------------------------------------------------------------
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  ctrl = '0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] rd;
    logic        z;
    logic        err;

    logic        m0_in_valid = 1'b0;
    logic        m0_in_ready;
    logic [3:0]  m0_ctrl = '0;
    logic [31:0] m0_rs1 = '0;
    logic [31:0] m0_rs2 = '0;
    logic        m0_out_valid;
    logic [31:0] m0_rd;
    logic        m0_z;
    logic        m0_err;

    logic        rdy_rand = 1'b0;
    logic        rdy_val = 1'b1;
    logic        rnd_bit = 1'b1;
    assign out_ready = rdy_rand ? rnd_bit : rdy_val;

    typedef struct {
        logic [31:0] rd;
        logic        z;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    bit   seen = 0;
    int   checks = 0;
    int   errors = 0;

    alu_mc #(.XLEN(32), .MULDIV_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ctrl(ctrl), .rs1(rs1), .rs2(rs2), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .rd(rd), .z(z), .err(err)
    );

    alu_mc #(.XLEN(32), .MULDIV_EN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(m0_in_valid), .in_ready(m0_in_ready),
        .ctrl(m0_ctrl), .rs1(m0_rs1), .rs2(m0_rs2), .flush(1'b0),
        .out_valid(m0_out_valid), .out_ready(1'b1), .rd(m0_rd), .z(m0_z), .err(m0_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1 rnd_bit = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain arithmetic on the architectural rules.
    function automatic logic [31:0] model_rd(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb_;
        logic signed [31:0] t;
        logic [63:0]        p;
        int                 sh;
        sa = a;
        sb_ = b;
        sh = int'(b % 32);
        p  = 64'(a) * 64'(b);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return (sa < sb_) ? 32'd1 : 32'd0;
            4'd6:  return (a < b) ? 32'd1 : 32'd0;
            4'd7:  return a << sh;
            4'd8:  return a >> sh;
            4'd9:  begin t = sa >>> sh; return t; end
            4'd10: return p[31:0];
            4'd11: return p[63:32];
            4'd12: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                t = sa / sb_; return t;
            end
            4'd13: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd14: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                t = sa % sb_; return t;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] op, input logic [31:0] b);
        if (op < 4'd10) return 1;
        if (op >= 4'd12 && b == 0) return 1;
        return 33;
    endfunction

    // Caller is positioned just after a rising edge; returns likewise.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int waited);
        exp_t e;
        waited = 0;
        in_valid = 1'b1; ctrl = op; rs1 = a; rs2 = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (in_ready) begin
                e.rd = model_rd(op, a, b); e.z = (a == b); e.err = 1'b0;
                e.lat = model_lat(op, b);  e.acc = cyc + 1;
                sb.push_back(e);
                @(posedge clk); #1;
                in_valid = 1'b0; ctrl = 4'($urandom); rs1 = $urandom; rs2 = $urandom;
                return;
            end
            @(posedge clk); #1;
            waited++;
        end
        chk("accept_timeout", 64'(waited), 64'(0));
        in_valid = 1'b0;
    endtask

    task automatic send1(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int w;
        send(op, a, b, w);
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (sb.size() == 0) return;
            @(posedge clk); #1;
        end
        chk("drain_timeout", 64'(sb.size()), 64'(0));
    endtask

    // Monitor: sampled at the falling edge, half a cycle from the active edge.
    always @(negedge clk) begin
        exp_t e;
        logic exp_rdy;
        if (rst_n) begin
            exp_rdy = !flush && (sb.size() == 0 || (out_valid && out_ready));
            chk("in_ready", 64'(in_ready), 64'(exp_rdy));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_out_valid: got 1 expected 0 (t=%0t)", $time);
                end else begin
                    e = sb[0];
                    if (!seen) begin
                        seen = 1;
                        chk("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
                    end
                    chk("rd", 64'(rd), 64'(e.rd));
                    chk("z", 64'(z), 64'(e.z));
                    chk("err", 64'(err), 64'(e.err));
                    if (out_ready) begin
                        void'(sb.pop_front());
                        seen = 0;
                    end
                end
            end
        end
    end

    initial begin
        #50000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [31:0] a, b;
        logic [3:0]  op;

        // Reset values
        #12;
        chk("rst_rd", 64'(rd), 64'(0));
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        @(negedge clk); #2 rst_n = 1'b1;
        @(negedge clk); #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_z", 64'(z), 64'(0));
        chk("rst0_rd", 64'(m0_rd), 64'(0));
        @(posedge clk); #1;

        // Simple ops, back-to-back
        send1(4'd0, 32'h7FFF_FFFF, 32'd1);
        send(4'd1, 32'd5, 32'd5, w);
        chk("back_to_back_wait", 64'(w), 64'(0));
        send1(4'd9, 32'h8000_0000, 32'h24);
        send1(4'd5, 32'hFFFF_FFFF, 32'd1);
        send1(4'd6, 32'hFFFF_FFFF, 32'd1);

        // Multiply / divide incl. boundaries
        send1(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        send1(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        send1(4'd12, 32'hFFFF_FFF9, 32'd2);
        send1(4'd14, 32'hFFFF_FFF9, 32'd2);
        send1(4'd13, 32'd10, 32'd0);
        send1(4'd14, 32'd10, 32'd0);
        send1(4'd14, 32'h8000_0000, 32'hFFFF_FFFF);
        send1(4'd12, 32'h8000_0000, 32'hFFFF_FFFF);
        drain();

        // Hold result with out_ready low, then consume+accept in one cycle
        rdy_val = 1'b0;
        send1(4'd0, 32'd1, 32'd2);
        repeat (5) begin @(posedge clk); #1; end
        @(negedge clk); #1;
        chk("hold_valid", 64'(out_valid), 64'(1));
        chk("hold_rd", 64'(rd), 64'(3));
        @(posedge clk); #1;
        rdy_val = 1'b1;
        send(4'd4, 32'hF0F0_1234, 32'h0FF0_4321, w);
        chk("consume_accept_wait", 64'(w), 64'(0));
        drain();

        // Flush mid-multiply, with an offered op that must be ignored
        send1(4'd10, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1; in_valid = 1'b1; ctrl = 4'd0; rs1 = 32'd1; rs2 = 32'd1;
        @(negedge clk); #1;
        chk("flush_in_ready", 64'(in_ready), 64'(0));
        sb.delete(); seen = 0;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk); #1;
        chk("flush_out_valid", 64'(out_valid), 64'(0));
        chk("flush_idle_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        send1(4'd0, 32'd2, 32'd3);
        drain();

        // Asynchronous reset mid-divide
        send1(4'd13, 32'hFFFF_1234, 32'd7);
        repeat (16) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        sb.delete(); seen = 0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'(0));
        chk("arst_rd", 64'(rd), 64'(0));
        chk("arst_z", 64'(z), 64'(0));
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk); #1;
        chk("arst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        send1(4'd0, 32'd2, 32'd3);
        drain();

        // MULDIV_EN = 0 instance
        m0_in_valid = 1'b1; m0_ctrl = 4'd10; m0_rs1 = 32'd3; m0_rs2 = 32'd5;
        @(negedge clk); #1;
        chk("m0_in_ready", 64'(m0_in_ready), 64'(1));
        @(posedge clk); #1;
        m0_ctrl = 4'd0; m0_rs1 = 32'd7; m0_rs2 = 32'd7;
        @(negedge clk); #1;
        chk("m0_mul_valid", 64'(m0_out_valid), 64'(1));
        chk("m0_mul_rd", 64'(m0_rd), 64'(0));
        chk("m0_mul_err", 64'(m0_err), 64'(1));
        @(posedge clk); #1;
        m0_in_valid = 1'b0;
        @(negedge clk); #1;
        chk("m0_add_rd", 64'(m0_rd), 64'(14));
        chk("m0_add_err", 64'(m0_err), 64'(0));
        chk("m0_add_z", 64'(m0_z), 64'(1));
        @(posedge clk); #1;

        // Randomised traffic with random back-pressure
        rdy_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom);
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: ;
                1: b = '0;
                2: b = a;
                3: begin a = $urandom_range(0, 100); b = $urandom_range(0, 9); end
                4: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: b = $urandom_range(0, 63);
            endcase
            send1(op, a, b);
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        drain();
        rdy_rand = 1'b0;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
